// File: rtl/spi_wb_bridge.sv
// SPI-to-Wishbone bridge, Wishbone clock domain.
// Takes bytes from an SPI Mode 0 shifter running on SCK and brings its
// strobe and chip select into wb_clk_i. It decodes a 3-byte
// command/address header. Each later byte becomes one Wishbone B4
// pipelined single-byte transfer. Read data goes back to the shifter on
// tx_data_o so it can be sent out on the next SPI byte.
module spi_wb_bridge #(
    parameter int SYNC_STAGES = 2,   // synchronizer depth, must be >= 2
    parameter int ADDR_WIDTH  = 17   // byte address width, must be >= 17
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_reset_i,
    input  logic                  spi_cs_ni,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_strobe_i,
    output logic [7:0]            tx_data_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [7:0]            wb_dat_o,
    input  logic [7:0]            wb_dat_i,
    output logic                  wb_we_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    input  logic                  wb_stall_i,
    input  logic                  wb_ack_i,
    output logic                  overrun_o
);

    typedef enum logic [2:0] {
        ST_CMD     = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_DATA    = 3'd3,
        ST_WB_REQ  = 3'd4,
        ST_WB_WAIT = 3'd5
    } state_t;

    state_t state_r;
    state_t state_s;

    // Synchronizer chains. Index 0 is the first flop and the MSB is the
    // settled value.
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] strobe_sync_r;
    logic                   cs_active_prev_r;
    logic                   strobe_prev_r;

    // Captured byte and its one-clock valid flag.
    logic                   byte_valid_r;
    logic [7:0]             rx_byte_r;

    // Frame context.
    logic                   inc_r;
    logic                   cs_lost_r;   // CS dropped while a bus cycle was open

    // Decoded conditions.
    logic                   cs_active_s;
    logic                   cs_start_s;
    logic                   strobe_rise_s;
    logic                   byte_evt_s;
    logic                   in_bus_s;

    // Actions from the next-state logic.
    logic                   ld_cmd_s;
    logic                   ld_hi_s;
    logic                   ld_lo_s;
    logic                   ld_wdat_s;
    logic                   issue_s;
    logic                   accept_s;
    logic                   ack_s;
    logic                   overrun_set_s;

    assign cs_active_s   = ~cs_sync_r[SYNC_STAGES-1];
    assign cs_start_s    = cs_active_s & ~cs_active_prev_r;
    assign strobe_rise_s = strobe_sync_r[SYNC_STAGES-1] & ~strobe_prev_r;
    assign byte_evt_s    = byte_valid_r & cs_active_s;
    assign in_bus_s      = (state_r == ST_WB_REQ) || (state_r == ST_WB_WAIT);

    // Bring chip select and the byte strobe into the Wishbone domain.
    // Both chains reset to their idle levels.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            cs_sync_r        <= {SYNC_STAGES{1'b1}};
            strobe_sync_r    <= {SYNC_STAGES{1'b0}};
            cs_active_prev_r <= 1'b0;
            strobe_prev_r    <= 1'b0;
        end else begin
            cs_sync_r        <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_ni};
            strobe_sync_r    <= {strobe_sync_r[SYNC_STAGES-2:0], rx_strobe_i};
            cs_active_prev_r <= cs_active_s;
            strobe_prev_r    <= strobe_sync_r[SYNC_STAGES-1];
        end
    end

    // Capture rx_data_i only on the strobe rising edge. By then the
    // shifter has held the byte stable for several SCK periods.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            byte_valid_r <= 1'b0;
            rx_byte_r    <= 8'h00;
        end else begin
            byte_valid_r <= strobe_rise_s;
            if (strobe_rise_s) begin
                rx_byte_r <= rx_data_i;
            end
        end
    end

    // Frame state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            state_r <= ST_CMD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and action decode. An open bus cycle is never abandoned:
    // a CS loss only takes effect once the ack arrives.
    always_comb begin
        state_s       = state_r;
        ld_cmd_s      = 1'b0;
        ld_hi_s       = 1'b0;
        ld_lo_s       = 1'b0;
        ld_wdat_s     = 1'b0;
        issue_s       = 1'b0;
        accept_s      = 1'b0;
        ack_s         = 1'b0;
        overrun_set_s = 1'b0;
        case (state_r)
            ST_CMD: begin
                if (byte_evt_s) begin
                    ld_cmd_s = 1'b1;
                    state_s  = ST_ADDR_HI;
                end else begin
                    state_s = ST_CMD;
                end
            end
            ST_ADDR_HI: begin
                if (!cs_active_s || cs_start_s) begin
                    state_s = ST_CMD;
                end else if (byte_evt_s) begin
                    ld_hi_s = 1'b1;
                    state_s = ST_ADDR_LO;
                end else begin
                    state_s = ST_ADDR_HI;
                end
            end
            ST_ADDR_LO: begin
                if (!cs_active_s || cs_start_s) begin
                    state_s = ST_CMD;
                end else if (byte_evt_s) begin
                    ld_lo_s = 1'b1;
                    if (wb_we_o) begin
                        state_s = ST_DATA;
                    end else begin
                        // Prefetch the first read byte.
                        issue_s = 1'b1;
                        state_s = ST_WB_REQ;
                    end
                end else begin
                    state_s = ST_ADDR_LO;
                end
            end
            ST_DATA: begin
                if (!cs_active_s || cs_start_s) begin
                    state_s = ST_CMD;
                end else if (byte_evt_s) begin
                    // Keep the payload on writes. On reads the byte is a
                    // dummy and only triggers the next prefetch.
                    ld_wdat_s = wb_we_o;
                    issue_s   = 1'b1;
                    state_s   = ST_WB_REQ;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_WB_REQ: begin
                overrun_set_s = byte_evt_s;
                if (wb_stb_o && !wb_stall_i) begin
                    accept_s = 1'b1;
                    state_s  = ST_WB_WAIT;
                end else begin
                    state_s = ST_WB_REQ;
                end
            end
            ST_WB_WAIT: begin
                overrun_set_s = byte_evt_s;
                if (wb_ack_i) begin
                    ack_s = 1'b1;
                    if (cs_lost_r || !cs_active_s) begin
                        state_s = ST_CMD;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_WB_WAIT;
                end
            end
            default: begin
                state_s = ST_CMD;
            end
        endcase
    end

    // Address, command flags and write data, loaded from the captured byte.
    // The address advances only after an ack, so it cannot change while a
    // cycle is open.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            wb_adr_o <= {ADDR_WIDTH{1'b0}};
            wb_we_o  <= 1'b0;
            inc_r    <= 1'b0;
            wb_dat_o <= 8'h00;
        end else begin
            if (ld_cmd_s) begin
                wb_we_o                     <= rx_byte_r[7];
                inc_r                       <= rx_byte_r[6];
                wb_adr_o[ADDR_WIDTH-1:16]   <= (ADDR_WIDTH-16)'(rx_byte_r[0]);
            end
            if (ld_hi_s) begin
                wb_adr_o[15:8] <= rx_byte_r;
            end
            if (ld_lo_s) begin
                wb_adr_o[7:0] <= rx_byte_r;
            end
            if (ld_wdat_s) begin
                wb_dat_o <= rx_byte_r;
            end
            if (ack_s && inc_r) begin
                wb_adr_o <= wb_adr_o + ADDR_WIDTH'(1);
            end
        end
    end

    // Bus handshake: cyc and stb rise together, stb drops after the
    // transfer is accepted, and cyc drops on the ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
        end else begin
            if (issue_s) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
            end else if (accept_s) begin
                wb_stb_o <= 1'b0;
            end else if (ack_s) begin
                wb_cyc_o <= 1'b0;
            end
        end
    end

    // Read data back to the shifter. It idles at all-ones, which is the
    // quiet MISO level.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            tx_data_o <= 8'hFF;
        end else if (ack_s && !wb_we_o) begin
            tx_data_o <= wb_dat_i;
        end
    end

    // Sticky overrun flag, cleared by the start of the next frame.
    // Also tracks whether CS was lost while a bus cycle was open.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            overrun_o <= 1'b0;
            cs_lost_r <= 1'b0;
        end else begin
            if (cs_start_s) begin
                overrun_o <= 1'b0;
            end else if (overrun_set_s) begin
                overrun_o <= 1'b1;
            end
            if (ack_s) begin
                cs_lost_r <= 1'b0;
            end else if (in_bus_s && !cs_active_s) begin
                cs_lost_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Self-checking bench for spi_wb_bridge. The bench plays the SPI shifter
// and a Wishbone byte memory slave whose stall and ack timing can be
// programmed. A frame-level reference model predicts the bus transfers
// and the read-back bytes.
module tb_spi_wb_bridge;

    localparam int SYNC = 2;
    localparam int AW   = 17;
    localparam int MEM_SIZE = 131072;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs_n;
    logic [7:0]    rx_data;
    logic          rx_strobe;
    logic [7:0]    tx_data;
    logic [AW-1:0] adr;
    logic [7:0]    dat_w;
    logic [7:0]    dat_r;
    logic          we;
    logic          cyc;
    logic          stb;
    logic          stall;
    logic          ack;
    logic          overrun;

    always #5 clk = ~clk;

    spi_wb_bridge #(.SYNC_STAGES(SYNC), .ADDR_WIDTH(AW)) dut (
        .wb_clk_i   (clk),
        .wb_reset_i (rst),
        .spi_cs_ni  (cs_n),
        .rx_data_i  (rx_data),
        .rx_strobe_i(rx_strobe),
        .tx_data_o  (tx_data),
        .wb_adr_o   (adr),
        .wb_dat_o   (dat_w),
        .wb_dat_i   (dat_r),
        .wb_we_o    (we),
        .wb_cyc_o   (cyc),
        .wb_stb_o   (stb),
        .wb_stall_i (stall),
        .wb_ack_i   (ack),
        .overrun_o  (overrun)
    );

    typedef struct {
        logic [AW-1:0] adr;
        logic          we;
        logic [7:0]    dat;
        int            stalls;
    } txn_t;

    int   n_cmp = 0;
    int   n_mis = 0;

    // Wishbone slave memory and its controls.
    logic [7:0]    mem [0:MEM_SIZE-1];
    txn_t          log_q[$];
    int            stall_clocks = 0;
    int            ack_delay = 0;
    int            stb_cnt;
    int            ack_left;
    logic          pend;
    logic [AW-1:0] pend_adr;
    logic          pend_we;
    logic [7:0]    pend_dat;

    // Reference model state.
    logic [7:0]    ref_mem [0:MEM_SIZE-1];
    logic [7:0]    frame_q[$];

    function automatic logic [7:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'hA5;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    assign stall = cyc && stb && (stb_cnt < stall_clocks);

    // Pipelined byte memory slave. It stalls for stall_clocks, acks
    // ack_delay+1 clocks after accepting, and logs every accepted request.
    always @(posedge clk) begin
        if (rst) begin
            stb_cnt <= 0;
            pend    <= 1'b0;
            ack     <= 1'b0;
            dat_r   <= 8'h00;
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= init_val(AW'(i));
        end else begin
            ack     <= 1'b0;
            stb_cnt <= (cyc && stb) ? stb_cnt + 1 : 0;
            if (pend) begin
                if (ack_left == 0) begin
                    ack   <= 1'b1;
                    dat_r <= mem[pend_adr];
                    if (pend_we) mem[pend_adr] <= pend_dat;
                    pend  <= 1'b0;
                end else begin
                    ack_left <= ack_left - 1;
                end
            end
            if (cyc && stb && !stall) begin
                pend     <= 1'b1;
                pend_adr <= adr;
                pend_we  <= we;
                pend_dat <= dat_w;
                ack_left <= ack_delay;
                log_q.push_back('{adr: adr, we: we, dat: dat_w, stalls: stb_cnt});
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = init_val(AW'(i));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data   = b;
        rx_strobe = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        rx_strobe = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (cyc && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, " bus idle"}, 32'(cyc), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_assert();
        cs_n = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    task automatic cs_release();
        cs_n = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    // Send frame_q as one CS-framed transaction. The model predicts every
    // transfer from the header rules, and each read result is checked
    // before the next byte is sent.
    task automatic run_frame(input string tag);
        int            base;
        logic          f_we;
        logic          f_inc;
        logic [AW-1:0] a;
        txn_t          exp_q[$];
        base  = log_q.size();
        f_we  = frame_q[0][7];
        f_inc = frame_q[0][6];
        a     = {frame_q[0][0], frame_q[1], frame_q[2]};
        cs_assert();
        for (int k = 0; k < frame_q.size(); k++) begin
            send_byte(frame_q[k]);
            wait_idle(tag);
            if (f_we && k >= 3) begin
                exp_q.push_back('{adr: a, we: 1'b1, dat: frame_q[k], stalls: 0});
                ref_mem[a] = frame_q[k];
                a = a + AW'(f_inc);
            end
            if (!f_we && k >= 2) begin
                exp_q.push_back('{adr: a, we: 1'b0, dat: 8'h00, stalls: 0});
                check_eq($sformatf("%s tx[%0d]", tag, k), 32'(tx_data), 32'(ref_mem[a]));
                a = a + AW'(f_inc);
            end
        end
        cs_release();
        check_eq({tag, " overrun"}, 32'(overrun), 32'd0);
        check_eq({tag, " count"}, 32'(log_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
            check_eq($sformatf("%s adr[%0d]", tag, i), 32'(log_q[base+i].adr), 32'(exp_q[i].adr));
            check_eq($sformatf("%s we[%0d]", tag, i), 32'(log_q[base+i].we), 32'(exp_q[i].we));
            if (exp_q[i].we) begin
                check_eq($sformatf("%s dat[%0d]", tag, i), 32'(log_q[base+i].dat), 32'(exp_q[i].dat));
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, " cyc"}, 32'(cyc), 32'd0);
        check_eq({tag, " stb"}, 32'(stb), 32'd0);
        check_eq({tag, " tx"}, 32'(tx_data), 32'hFF);
        check_eq({tag, " adr"}, 32'(adr), 32'd0);
        check_eq({tag, " overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            base;
        int            n;
        logic          r_we;
        logic          r_inc;
        logic [AW-1:0] r_a;

        rst       = 1'b1;
        cs_n      = 1'b1;
        rx_strobe = 1'b0;
        rx_data   = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        check_eq("reset we", 32'(we), 32'd0);
        check_eq("reset dat", 32'(dat_w), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write with auto-increment at 0x08000.
        frame_q = '{8'hC0, 8'h80, 8'h00, 8'h11, 8'h22, 8'h33};
        base = log_q.size();
        run_frame("wr_inc");
        check_eq("wr_inc first adr", 32'(log_q[base].adr), 32'h08000);

        // Store 0x5A at 0x1E800, then read it twice without increment.
        frame_q = '{8'h81, 8'hE8, 8'h00, 8'h5A};
        run_frame("wr_5a");
        frame_q = '{8'h01, 8'hE8, 8'h00, 8'h00};
        run_frame("rd_noinc");
        check_eq("rd_noinc tx 5A", 32'(tx_data), 32'h5A);

        // Address wrap from 0x1FFFF to 0x00000, with a stalled slave.
        stall_clocks = 3;
        frame_q = '{8'hC1, 8'hFF, 8'hFF, 8'hD1, 8'hD2};
        base = log_q.size();
        run_frame("wrap");
        check_eq("wrap stalls", 32'(log_q[base].stalls), 32'd3);
        check_eq("wrap adr0", 32'(log_q[base].adr), 32'h1FFFF);
        check_eq("wrap adr1", 32'(log_q[base+1].adr), 32'h00000);
        stall_clocks = 0;

        // Overrun: a second byte arrives while the first write waits for ack.
        ack_delay = 40;
        base = log_q.size();
        cs_assert();
        send_byte(8'hC0); wait_idle("ovr");
        send_byte(8'h00); wait_idle("ovr");
        send_byte(8'h10); wait_idle("ovr");
        send_byte(8'hAB);
        repeat (6) @(negedge clk);
        check_eq("ovr cyc busy", 32'(cyc), 32'd1);
        send_byte(8'hCD);
        wait_idle("ovr");
        ref_mem[17'h00010] = 8'hAB;
        check_eq("ovr flag", 32'(overrun), 32'd1);
        check_eq("ovr count", 32'(log_q.size() - base), 32'd1);
        check_eq("ovr dat", 32'(log_q[base].dat), 32'hAB);
        cs_release();
        check_eq("ovr sticky", 32'(overrun), 32'd1);
        cs_assert();
        check_eq("ovr cleared", 32'(overrun), 32'd0);
        cs_release();

        // CS rises during WB_WAIT: the cycle still completes.
        ack_delay = 20;
        base = log_q.size();
        cs_assert();
        send_byte(8'h00); wait_idle("abort");
        send_byte(8'h01); wait_idle("abort");
        send_byte(8'h23);
        n = 0;
        while (!(cyc && !stb) && n < 100) begin
            @(negedge clk);
            n++;
        end
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("abort cyc held", 32'(cyc), 32'd1);
        wait_idle("abort");
        check_eq("abort tx", 32'(tx_data), 32'(ref_mem[17'h00123]));
        check_eq("abort count", 32'(log_q.size() - base), 32'd1);
        check_eq("abort adr", 32'(log_q[base].adr), 32'h00123);
        repeat (SYNC + 3) @(negedge clk);
        ack_delay = 0;
        frame_q = '{8'hC0, 8'h45, 8'h67, 8'h77, 8'h78};
        run_frame("post_abort_wr");
        frame_q = '{8'h40, 8'h45, 8'h67, 8'h00};
        run_frame("post_abort_rd");

        // Reset while a request is held in WB_REQ by the stall.
        stall_clocks = 50;
        cs_assert();
        send_byte(8'h01);
        repeat (4) @(negedge clk);
        send_byte(8'h00);
        repeat (4) @(negedge clk);
        send_byte(8'h40);
        n = 0;
        while (!stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_req stb up", 32'(stb), 32'd1);
        rst = 1'b1;
        cs_n = 1'b1;
        @(negedge clk);
        check_reset_state("rst_req");
        @(negedge clk);
        rst = 1'b0;
        stall_clocks = 0;
        model_reset();
        repeat (SYNC + 3) @(negedge clk);
        frame_q = '{8'h41, 8'h00, 8'h40, 8'h00};
        run_frame("post_rst_rd");

        // Random frames with random stall and ack timing.
        for (int f = 0; f < 25; f++) begin
            r_we  = 1'($urandom_range(0, 1));
            r_inc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) r_a = 17'h1FFFE + AW'($urandom_range(0, 1));
            else r_a = AW'($urandom);
            frame_q.delete();
            frame_q.push_back({r_we, r_inc, 5'($urandom), r_a[16]});
            frame_q.push_back(r_a[15:8]);
            frame_q.push_back(r_a[7:0]);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) frame_q.push_back(8'($urandom));
            stall_clocks = $urandom_range(0, 3);
            ack_delay    = $urandom_range(0, 4);
            run_frame($sformatf("rand%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
